tt_sweep: RTL and testbench
===========================

TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 The block SHALL have parameter N_IN, default 3: number of stimulus inputs, legal range 1..6.
REQ-002 The block SHALL have parameter HOLD, default 10: cycles each input pattern is held, legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 The block SHALL have port start, input, 1: request a sweep; honoured only in IDLE.
REQ-006 The block SHALL have port stim, output, N_IN: pattern driven to the device under test; MSB is the first-named input.
REQ-007 The block SHALL have port f_in, input, 1: response of the device under test.
REQ-008 The block SHALL have port busy, output, 1: high while a sweep is in progress.
REQ-009 The block SHALL have port done, output, 1: single-cycle pulse at sweep completion.
REQ-010 The block SHALL have port table_out, output, 2**N_IN: captured truth table; bit i is the response to stim==i.

Function
REQ-011 The FSM SHALL have three states: IDLE, DRIVE and DONE.
REQ-012 In IDLE with start=1 at an edge, the FSM SHALL go to DRIVE and set stim=0, hold count=0, busy=1 and table_out=0.
REQ-013 In DRIVE, each stim value SHALL be held exactly HOLD cycles.
REQ-014 At the edge ending the HOLD-th cycle of a pattern, f_in SHALL be written to table_out[stim].
REQ-015 After that write, if stim < 2**N_IN-1, stim SHALL increment by 1 and the hold count SHALL restart.
REQ-016 After the write for stim == 2**N_IN-1, the FSM SHALL go to DONE.
REQ-017 In DONE, done SHALL be 1 and busy SHALL be 0 for exactly one cycle; stim SHALL return to 0 and the FSM SHALL return to IDLE.
REQ-018 Latency: with start sampled at edge E0, done SHALL be high in the cycle after edge E0+(2**N_IN)*HOLD.
REQ-019 start SHALL be ignored in DRIVE and DONE; a sweep SHALL never restart mid-run.
REQ-020 table_out SHALL hold its value in IDLE until the next accepted start.
REQ-021 Stim SHALL wrap only via DONE; no pattern repeats within a sweep.
REQ-022 With HOLD=1, one pattern SHALL advance per cycle with no idle gap.

Reset
REQ-023 On rst=1, asynchronously: state=IDLE, stim=0, busy=0, done=0, table_out=0 and the hold count=0.
REQ-024 A reset mid-sweep SHALL abort the sweep with no done pulse.
REQ-025 After reset release, the block SHALL accept start at the first edge.

Configuration
REQ-026 Macro TT_SWEEP_CHECK_EN defined: the block SHALL add port exp_table (input, 2**N_IN), mismatch (output, 1) and mm_index (output, N_IN).
REQ-027 With TT_SWEEP_CHECK_EN, at each sample, f_in != exp_table[stim] while mismatch=0 SHALL set mismatch=1 and mm_index=stim.
REQ-028 With TT_SWEEP_CHECK_EN, later mismatches SHALL not change mm_index.
REQ-029 With TT_SWEEP_CHECK_EN, mismatch and mm_index SHALL clear on reset and on an accepted start.
REQ-030 Macro TT_SWEEP_CHECK_EN undefined: exp_table, mismatch and mm_index SHALL be absent and there SHALL be no compare logic; all other behaviour SHALL be unchanged.

Structure
REQ-031 Package tt_sweep_pkg SHALL hold the state enum (IDLE/DRIVE/DONE), N_IN_MAX=6 and HOLD_MAX=255.
REQ-032 Sub-module tt_hold_timer SHALL contain the HOLD down-counter, with ports load and a last-cycle flag.

Verification
REQ-033 N_IN=3, HOLD=10, DUT=majority, pulse start -> stim steps 0..7 every 10 cycles, done 80 cycles after start, table_out=8'b11101000.
REQ-034 With TT_SWEEP_CHECK_EN, exp_table=8'b11101001 against the majority DUT -> mismatch=1, mm_index=0 from the first sample onward.
REQ-035 start re-pulsed at cycle 40 of a sweep -> ignored, done still at cycle 80, table_out unchanged from REQ-033.
REQ-036 rst pulsed at cycle 35 -> outputs immediately 0, no done; a new start then yields a full correct sweep.
REQ-037 N_IN=1, HOLD=1, DUT=inverter -> table_out=2'b01, done 2 cycles after start.
REQ-038 start held high continuously -> back-to-back sweeps, each separated by exactly one DONE cycle plus the IDLE accept edge.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: FSM states and parameter limits shared by the truth-table sweeper.
package tt_sweep_pkg;
  localparam int N_IN_MAX = 6;
  localparam int HOLD_MAX = 255;
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_e;
endpackage

// File: rtl/tt_hold_timer.sv
// tt_hold_timer: down-counter that flags the final cycle of each HOLD-cycle pattern.
module tt_hold_timer
  import tt_sweep_pkg::*;
#(
  parameter int HOLD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last
);
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  assign last = cnt_q == '0;
  always_comb cnt_d = load ? HOLD_W'(HOLD - 1) : (en && !last) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/tt_sweep.sv
// tt_sweep: drives every input pattern for HOLD cycles and captures the response truth table.
// Define TT_SWEEP_CHECK_EN to add the expected-table compare (exp_table/mismatch/mm_index).
module tt_sweep
  import tt_sweep_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int HOLD = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      stim,
  input  logic                 f_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out
`ifdef TT_SWEEP_CHECK_EN
  ,
  input  logic [2**N_IN-1:0]   exp_table,
  output logic                 mismatch,
  output logic [N_IN-1:0]      mm_index
`endif
);
  localparam logic [N_IN-1:0] STIM_MAX = '1;
  state_e state_q;
  logic [N_IN-1:0] stim_q;
  logic [2**N_IN-1:0] table_q;
  logic busy_q, done_q, last, accept, sample;
  assign accept = state_q == IDLE && start;
  assign sample = state_q == DRIVE && last;
  assign stim = stim_q;
  assign busy = busy_q;
  assign done = done_q;
  assign table_out = table_q;
  tt_hold_timer #(.HOLD(HOLD)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (accept || (sample && stim_q != STIM_MAX)),
    .en   (state_q == DRIVE),
    .last (last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      stim_q  <= '0;
      table_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q <= DRIVE;
        stim_q  <= '0;
        table_q <= '0;
        busy_q  <= 1'b1;
      end else if (sample) begin
        table_q[stim_q] <= f_in;
        if (stim_q == STIM_MAX) begin
          state_q <= DONE;
          stim_q  <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else stim_q <= stim_q + 1'b1;
      end else if (state_q == DONE) state_q <= IDLE;
    end
`ifdef TT_SWEEP_CHECK_EN
  logic mm_q;
  logic [N_IN-1:0] mm_idx_q;
  assign mismatch = mm_q;
  assign mm_index = mm_idx_q;
  // Only the first differing pattern is latched for the whole sweep.
  always_ff @(posedge clk or posedge rst)
    if (rst || accept) begin
      mm_q     <= 1'b0;
      mm_idx_q <= '0;
    end else if (sample && !mm_q && f_in != exp_table[stim_q]) begin
      mm_q     <= 1'b1;
      mm_idx_q <= stim_q;
    end
`endif
endmodule

// File: tb/tb_tt_sweep.sv
// tb_tt_sweep: randomized scoreboard bench for tt_sweep (N_IN=3/HOLD=10 and N_IN=1/HOLD=1).
module tb_tt_sweep;
  localparam int N = 3;
  localparam int H = 10;
  localparam int SW = (2 ** N) * H;
  typedef struct {
    int         e0;
    logic [7:0] tbl;
    logic       mm;
    logic [2:0] idx;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start1 = 1'b0;
  logic [2:0] stim;
  logic [0:0] stim1;
  logic busy, done, busy1, done1;
  logic [7:0] table_out, tt_cur = '0, exp_tab = '0;
  logic [1:0] tbl1;
  logic f_in, f1;
  int cyc = 0, n_cmp = 0, n_bad = 0, mj;
  exp_t sbq[$];
  assign f_in = tt_cur[stim];
  assign f1 = ~stim1[0];
`ifdef TT_SWEEP_CHECK_EN
  logic mismatch, mism1;
  logic [2:0] mm_index;
  logic [0:0] mmi1;
`endif
  tt_sweep #(.N_IN(N), .HOLD(H)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stim(stim), .f_in(f_in),
    .busy(busy), .done(done), .table_out(table_out)
`ifdef TT_SWEEP_CHECK_EN
    , .exp_table(exp_tab), .mismatch(mismatch), .mm_index(mm_index)
`endif
  );
  tt_sweep #(.N_IN(1), .HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .stim(stim1), .f_in(f1),
    .busy(busy1), .done(done1), .table_out(tbl1)
`ifdef TT_SWEEP_CHECK_EN
    , .exp_table(2'b01), .mismatch(mism1), .mm_index(mmi1)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  function automatic exp_t mk(input int e0, input logic [7:0] tt, input logic [7:0] ex);
    exp_t it;
    it.e0 = e0; it.tbl = tt; it.mm = 1'b0; it.idx = '0;
    for (int i = 0; i < 8; i++)
      if (!it.mm && tt[i] != ex[i]) begin it.mm = 1'b1; it.idx = 3'(i); end
    return it;
  endfunction
  // Monitor: expected sweep progress is derived from cycles elapsed since the accept edge.
  always @(negedge clk)
    if (!rst) begin
      if (sbq.size() > 0 && cyc >= sbq[0].e0) begin
        mj = cyc - sbq[0].e0;
        if (mj < SW)
          chk("sweep", {busy, done, stim, table_out},
              {1'b1, 1'b0, 3'(mj / H), sbq[0].tbl & ((8'd1 << (mj / H)) - 8'd1)});
        else begin
          chk("done", {busy, done, stim, table_out}, {1'b0, 1'b1, 3'd0, sbq[0].tbl});
`ifdef TT_SWEEP_CHECK_EN
          chk("mismatch", {mismatch, mm_index}, {sbq[0].mm, sbq[0].idx});
`endif
          void'(sbq.pop_front());
        end
      end else chk("idle", {busy, done}, 2'b00);
    end
  task automatic wait_empty(input int bound);
    for (int k = 0; k < bound && sbq.size() > 0; k++) begin
      @(posedge clk); #1;
    end
    chk("timeout", sbq.size(), 0);
  endtask
  task automatic sweep_go(input logic [7:0] tt, input logic [7:0] ex, input int ign_at);
    int e0;
    tt_cur = tt; exp_tab = ex; start = 1'b1; e0 = cyc + 1;
    sbq.push_back(mk(e0, tt, ex));
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < SW + 20 && sbq.size() > 0; k++) begin
      @(posedge clk); #1;
      start = (cyc == e0 + ign_at - 1);
    end
    start = 1'b0;
    chk("timeout", sbq.size(), 0);
    repeat (5) @(posedge clk);
    #1 chk("hold", table_out, tt);
  endtask
  initial begin
    int e0;
    #3 chk("rst_out", {busy, done, stim, table_out, busy1, done1, stim1, tbl1}, '0);
    @(posedge clk); #1 rst = 1'b0;
    sweep_go(8'b11101000, 8'b11101001, -1);
    sweep_go(8'b11101000, 8'b11101000, 40);
    repeat (4) sweep_go(8'($urandom), 8'($urandom), -1);
    tt_cur = 8'($urandom); start = 1'b1; e0 = cyc + 1;
    sbq.push_back(mk(e0, tt_cur, exp_tab));
    @(posedge clk); #1 start = 1'b0;
    repeat (35) @(posedge clk);
    #2 rst = 1'b1; sbq.delete();
    #1 chk("rst_mid", {busy, done, stim, table_out}, '0);
`ifdef TT_SWEEP_CHECK_EN
    chk("rst_mm", {mismatch, mm_index}, '0);
`endif
    @(posedge clk); #1 rst = 1'b0;
    sweep_go(8'($urandom), 8'($urandom), -1);
    tt_cur = 8'($urandom); exp_tab = tt_cur; start = 1'b1; e0 = cyc + 1;
    for (int s = 0; s < 3; s++) sbq.push_back(mk(e0 + s * (SW + 2), tt_cur, exp_tab));
    wait_empty(3 * (SW + 2) + 20);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start1 = 1'b1; e0 = cyc + 1;
    @(posedge clk); #1 start1 = 1'b0;
    @(negedge clk) chk("n1_s0", {busy1, done1, stim1}, 3'b100);
    @(negedge clk) chk("n1_s1", {busy1, done1, stim1}, 3'b101);
    @(negedge clk) chk("n1_done", {busy1, done1, stim1, tbl1}, 5'b01001);
    chk("n1_lat", cyc - e0, 2);
`ifdef TT_SWEEP_CHECK_EN
    chk("n1_mm", mism1, 1'b0);
`endif
    @(negedge clk) chk("n1_idle", {busy1, done1, tbl1}, 4'b0001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
